// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC parallel-bus sequencer: FSM states, RTC register map,
// command-register codes and default bus timing.
package rtc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StASu,
    StAStb,
    StAHold,
    StAGap,
    StDSu,
    StDStb,
    StDHold,
    StDGap,
    StFin
  } rtc_state_e;

  // RTC register file addresses
  localparam logic [7:0] RegSeconds = 8'h00;
  localparam logic [7:0] RegMinutes = 8'h01;
  localparam logic [7:0] RegHours   = 8'h02;
  localparam logic [7:0] RegDay     = 8'h03;
  localparam logic [7:0] RegDate    = 8'h04;
  localparam logic [7:0] RegMonth   = 8'h05;
  localparam logic [7:0] RegYears   = 8'h06;
  localparam logic [7:0] RegTimer   = 8'h07;
  localparam logic [7:0] RegStatus0 = 8'h08;
  localparam logic [7:0] RegStatus1 = 8'h09;
  localparam logic [7:0] RegStatus2 = 8'h0A;

  // Command-register codes written by the prefix access
  localparam logic [7:0] CmdClkXfer = 8'hF0;
  localparam logic [7:0] CmdTmrXfer = 8'hF1;
  localparam logic [7:0] CmdAuxXfer = 8'hF2;

  localparam int unsigned TSuDef    = 2;
  localparam int unsigned TPulseDef = 4;
  localparam int unsigned THoldDef  = 2;
  localparam int unsigned TGapDef   = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times each bus phase; tc_o flags the last cycle of a phase.
module rtc_phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_seq.sv
// Burst sequencer for the RTC multiplexed address/data bus: optional command-register
// prefix write, then len register accesses with programmable phase timing.
module rtc_bus_seq
  import rtc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       MAX_LEN  = 16,
  parameter int unsigned       T_SU     = TSuDef,
  parameter int unsigned       T_PULSE  = TPulseDef,
  parameter int unsigned       T_HOLD   = THoldDef,
  parameter int unsigned       T_GAP    = TGapDef,
  parameter logic [DATA_W-1:0] CMD_ADDR = DATA_W'(CmdClkXfer)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic                         cmd_prefix,
  input  logic [DATA_W-1:0]            cmd_pdata,
  input  logic [DATA_W-1:0]            cmd_addr,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  output logic [$clog2(MAX_LEN)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         rd_valid,
  output logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         done,
  output logic                         a_d,
  output logic                         cs,
  output logic                         rd,
  output logic                         wr,
  output logic [DATA_W-1:0]            ad_out,
  output logic                         ad_oe,
  input  logic [DATA_W-1:0]            ad_in
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW = $clog2(MAX_LEN);
  localparam int unsigned TMax = max_u(max_u(T_SU, T_PULSE), max_u(T_HOLD, T_GAP));
  localparam int unsigned TmrW = (TMax > 1) ? $clog2(TMax) : 1;

  rtc_state_e state_d, state_q;

  logic              write_d, write_q;
  logic              pfx_d, pfx_q;
  logic [DATA_W-1:0] pdata_d, pdata_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic [LenW-1:0]   rem_d, rem_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0] ad_out_d, ad_out_q;
  logic              rd_valid_d, rd_valid_q;
  logic [IdxW-1:0]   rd_idx_d, rd_idx_q;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  logic            tmr_load, tmr_tc;
  logic [TmrW-1:0] tmr_val;
  logic            acc_wr, last_acc, accept;
  logic [LenW-1:0] len_clamped;

  assign accept      = (state_q == StIdle) && cmd_valid;
  assign acc_wr      = pfx_q | write_q;
  assign len_clamped = (cmd_len > LenW'(MAX_LEN)) ? LenW'(MAX_LEN) : cmd_len;
  // rem_q counts burst accesses still owed, including the one in flight
  assign last_acc    = pfx_q ? (rem_q == '0) : (rem_q == LenW'(1));

  rtc_phase_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = (cmd_prefix || cmd_len != '0) ? StASu : StFin;
      StASu:   if (tmr_tc) state_d = StAStb;
      StAStb:  if (tmr_tc) state_d = StAHold;
      StAHold: if (tmr_tc) state_d = StAGap;
      StAGap:  if (tmr_tc) state_d = StDSu;
      StDSu:   if (tmr_tc) state_d = StDStb;
      StDStb:  if (tmr_tc) state_d = StDHold;
      StDHold: if (tmr_tc) state_d = StDGap;
      StDGap:  if (tmr_tc) state_d = last_acc ? StFin : StASu;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Every state change enters a fresh phase, so the timer reloads on any transition
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      StASu, StDSu:     tmr_val = TmrW'(T_SU - 1);
      StAStb, StDStb:   tmr_val = TmrW'(T_PULSE - 1);
      StAHold, StDHold: tmr_val = TmrW'(T_HOLD - 1);
      StAGap, StDGap:   tmr_val = TmrW'(T_GAP - 1);
      default:          tmr_val = '0;
    endcase
  end

  always_comb begin
    cs    = 1'b1;
    rd    = 1'b1;
    wr    = 1'b1;
    a_d   = 1'b1;
    ad_oe = 1'b0;
    unique case (state_q)
      StASu, StAHold: begin
        cs    = 1'b0;
        a_d   = 1'b0;
        ad_oe = 1'b1;
      end
      StAStb: begin
        cs    = 1'b0;
        a_d   = 1'b0;
        ad_oe = 1'b1;
        wr    = 1'b0;
      end
      StAGap: a_d = 1'b0;
      StDSu, StDHold: begin
        cs    = 1'b0;
        ad_oe = acc_wr;
      end
      StDStb: begin
        cs    = 1'b0;
        ad_oe = acc_wr;
        wr    = ~acc_wr;
        rd    = acc_wr;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign done      = (state_q == StFin);
  assign ad_out    = ad_out_q;
  assign wr_idx    = idx_q;
  assign rd_valid  = rd_valid_q;
  assign rd_idx    = rd_idx_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    write_d    = write_q;
    pfx_d      = pfx_q;
    pdata_d    = pdata_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    ad_out_d   = ad_out_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;

    if (accept) begin
      write_d = cmd_write;
      pfx_d   = cmd_prefix;
      pdata_d = cmd_pdata;
      addr_d  = cmd_addr;
      rem_d   = len_clamped;
      idx_d   = '0;
    end

    if (state_q == StDGap && tmr_tc) begin
      if (pfx_q) begin
        pfx_d = 1'b0;
      end else begin
        rem_d = rem_q - LenW'(1);
        if (!last_acc) idx_d = idx_q + IdxW'(1);
      end
    end

    if (state_d == StASu && state_q != StASu) begin
      ad_out_d = pfx_d ? CMD_ADDR : addr_d + DATA_W'(idx_d);
    end

    // Read accesses keep the address on ad_out; the bus is released via ad_oe
    if (state_d == StDSu && state_q == StAGap && acc_wr) begin
      ad_out_d = pfx_q ? pdata_q : wr_data;
    end

    if (state_q == StDStb && tmr_tc && !acc_wr) begin
      rd_valid_d = 1'b1;
      rd_idx_d   = idx_q;
      rd_data_d  = ad_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q    <= 1'b0;
      pfx_q      <= 1'b0;
      pdata_q    <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      ad_out_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      write_q    <= write_d;
      pfx_q      <= pfx_d;
      pdata_q    <= pdata_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      ad_out_q   <= ad_out_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Bench for rtc_bus_seq: a trace-expanding model of the bus protocol checked every cycle,
// an RTC bus model that latches addresses and captures writes, and directed commands.
module tb_rtc_bus_seq;

  localparam int unsigned TSu = 2, TPulse = 4, THold = 2, TGap = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic       cmd_prefix = 1'b0;
  logic [7:0] cmd_pdata = 8'h00;
  logic [7:0] cmd_addr = 8'h00;
  logic [4:0] cmd_len = 5'd0;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic       done;
  logic       a_d, cs, rd, wr, ad_oe;
  logic [7:0] ad_out;
  logic [7:0] ad_in;

  logic [7:0] wr_base = 8'h00;
  logic [7:0] rd_mem [256];
  logic [7:0] wr_log [256] = '{default: 8'h00};
  logic [7:0] lat_q = 8'h00;

  int checks = 0;
  int errors = 0;
  int wr_low_cnt = 0;
  int cs_low_cnt = 0;
  logic [11:0] rd_log [$];

  always #5 clk = ~clk;

  assign wr_data = wr_base + {4'h0, wr_idx};
  assign ad_in   = rd_mem[lat_q];

  rtc_bus_seq #(
    .DATA_W   (8),
    .MAX_LEN  (16),
    .T_SU     (TSu),
    .T_PULSE  (TPulse),
    .T_HOLD   (THold),
    .T_GAP    (TGap),
    .CMD_ADDR (8'hF0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_prefix (cmd_prefix),
    .cmd_pdata  (cmd_pdata),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .done       (done),
    .a_d        (a_d),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .ad_in      (ad_in)
  );

  // RTC side: address latched while wr strobes in the address phase, data captured likewise
  always @(posedge clk) begin
    if (!cs && !a_d && !wr) lat_q <= ad_out;
    if (!cs && a_d && !wr && ad_oe) wr_log[lat_q] <= ad_out;
  end

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       a_d;
    logic       ad_oe;
    logic       rd_valid;
    logic [7:0] ad_out;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;
  } exp_t;

  localparam exp_t IdleRec = '{ready: 1'b1, done: 1'b0, cs: 1'b1, rd: 1'b1, wr: 1'b1,
                               a_d: 1'b1, ad_oe: 1'b0, rd_valid: 1'b0, ad_out: 8'h00,
                               rd_idx: 4'h0, rd_data: 8'h00};

  exp_t exp_q [$];
  exp_t cur = IdleRec;

  task automatic push_phase(input int unsigned n, input logic cs_v, input logic rd_v,
                            input logic wr_v, input logic ad_v, input logic oe_v,
                            input logic [7:0] out_v, input logic rv,
                            input logic [3:0] ridx, input logic [7:0] rdat);
    exp_t r;
    for (int unsigned k = 0; k < n; k++) begin
      r = IdleRec;
      r.ready = 1'b0;
      r.cs = cs_v;
      r.rd = rd_v;
      r.wr = wr_v;
      r.a_d = ad_v;
      r.ad_oe = oe_v;
      r.ad_out = out_v;
      r.rd_valid = rv && (k == 0);
      r.rd_idx = ridx;
      r.rd_data = rdat;
      exp_q.push_back(r);
    end
  endtask

  // One access expanded into its cycle-by-cycle bus picture
  task automatic gen_access(input logic [7:0] a, input logic w, input logic [7:0] d,
                            input logic [3:0] ridx, input logic [7:0] rdat);
    push_phase(TSu,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, 1'b0, 4'h0, 8'h00);
    push_phase(TPulse, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0, 4'h0, 8'h00);
    push_phase(THold,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, 1'b0, 4'h0, 8'h00);
    push_phase(TGap,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a, 1'b0, 4'h0, 8'h00);
    push_phase(TSu,    1'b0, 1'b1, 1'b1, 1'b1, w, d, 1'b0, 4'h0, 8'h00);
    push_phase(TPulse, 1'b0, w, ~w, 1'b1, w, d, 1'b0, 4'h0, 8'h00);
    push_phase(THold,  1'b0, 1'b1, 1'b1, 1'b1, w, d, ~w, ridx, rdat);
    push_phase(TGap,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, d, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic gen_cmd();
    int unsigned n;
    logic [7:0] a;
    exp_t r;
    n = (cmd_len > 5'd16) ? 16 : int'(cmd_len);
    if (cmd_prefix) gen_access(8'hF0, 1'b1, cmd_pdata, 4'h0, 8'h00);
    for (int unsigned i = 0; i < n; i++) begin
      a = cmd_addr + 8'(i);
      if (cmd_write) gen_access(a, 1'b1, wr_base + 8'(i), 4'h0, 8'h00);
      else gen_access(a, 1'b0, 8'h00, 4'(i), rd_mem[a]);
    end
    r = IdleRec;
    r.ready = 1'b0;
    r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      cur <= IdleRec;
    end else if (exp_q.size() > 0) begin
      cur <= exp_q.pop_front();
    end else if (cur.ready && cmd_valid) begin
      gen_cmd();
      cur <= exp_q.pop_front();
    end else begin
      cur <= IdleRec;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(cur.ready));
    chk("done", 32'(done), 32'(cur.done));
    chk("cs", 32'(cs), 32'(cur.cs));
    chk("rd", 32'(rd), 32'(cur.rd));
    chk("wr", 32'(wr), 32'(cur.wr));
    chk("a_d", 32'(a_d), 32'(cur.a_d));
    chk("ad_oe", 32'(ad_oe), 32'(cur.ad_oe));
    chk("rd_valid", 32'(rd_valid), 32'(cur.rd_valid));
    if (cur.ad_oe) chk("ad_out", 32'(ad_out), 32'(cur.ad_out));
    if (cur.rd_valid) begin
      chk("rd_idx", 32'(rd_idx), 32'(cur.rd_idx));
      chk("rd_data", 32'(rd_data), 32'(cur.rd_data));
    end
    if (!wr) wr_low_cnt++;
    if (!cs) cs_low_cnt++;
    if (rd_valid) rd_log.push_back({rd_idx, rd_data});
  end

  task automatic issue(input logic w, input logic p, input logic [7:0] pd,
                       input logic [7:0] a, input logic [4:0] l);
    @(negedge clk);
    #1;
    cmd_write = w;
    cmd_prefix = p;
    cmd_pdata = pd;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 2000);
    if (!done) chk({name, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  int lat;
  int base_wr, base_cs, base_rd;

  initial begin
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i) ^ 8'h5A;
    rd_mem[8'h21] = 8'h45;
    rd_mem[8'h22] = 8'h30;
    rd_mem[8'h60] = 8'h77;

    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Write 21h.., len 3
    wr_base = 8'h10;
    base_wr = wr_low_cnt;
    issue(1'b1, 1'b0, 8'h00, 8'h21, 5'd3);
    wait_done("wr3", lat);
    chk("wr3_latency", 32'(lat), 32'd73);
    chk("wr3_mem21", 32'(wr_log[8'h21]), 32'h10);
    chk("wr3_mem22", 32'(wr_log[8'h22]), 32'h11);
    chk("wr3_mem23", 32'(wr_log[8'h23]), 32'h12);
    chk("wr3_wr_low", 32'(wr_low_cnt - base_wr), 32'd24);

    // Read with prefix
    issue(1'b0, 1'b1, 8'hF0, 8'h21, 5'd2);
    wait_done("rdp", lat);
    chk("rdp_latency", 32'(lat), 32'd73);
    chk("rdp_prefix", 32'(wr_log[8'hF0]), 32'hF0);
    chk("rdp_count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      chk("rdp_first", 32'(rd_log[0]), 32'h045);
      chk("rdp_second", 32'(rd_log[1]), 32'h130);
    end

    // Address wrap
    wr_base = 8'hA0;
    issue(1'b1, 1'b0, 8'h00, 8'hFF, 5'd2);
    wait_done("wrap", lat);
    chk("wrap_memFF", 32'(wr_log[8'hFF]), 32'hA0);
    chk("wrap_mem00", 32'(wr_log[8'h00]), 32'hA1);

    // len 0 without prefix
    base_cs = cs_low_cnt;
    issue(1'b1, 1'b0, 8'h00, 8'h30, 5'd0);
    wait_done("len0", lat);
    chk("len0_latency", 32'(lat), 32'd1);
    chk("len0_cs_idle", 32'(cs_low_cnt - base_cs), 32'd0);

    // len 0 with prefix
    base_cs = cs_low_cnt;
    issue(1'b0, 1'b1, 8'h5A, 8'h30, 5'd0);
    wait_done("len0p", lat);
    chk("len0p_latency", 32'(lat), 32'd25);
    chk("len0p_prefix", 32'(wr_log[8'hF0]), 32'h5A);
    chk("len0p_cs_low", 32'(cs_low_cnt - base_cs), 32'd16);

    // Reset in the middle of a read strobe
    base_rd = rd_log.size();
    issue(1'b0, 1'b0, 8'h00, 8'h60, 5'd1);
    repeat (16) @(negedge clk);
    chk("pre_reset_rd", 32'(rd), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_rd", 32'(rd), 32'd1);
    chk("rst_wr", 32'(wr), 32'd1);
    chk("rst_oe", 32'(ad_oe), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_no_rd_valid", 32'(rd_log.size() - base_rd), 32'd0);

    // cmd_valid held while busy
    wr_base = 8'hC0;
    @(negedge clk);
    #1;
    cmd_write = 1'b1;
    cmd_prefix = 1'b0;
    cmd_addr = 8'h40;
    cmd_len = 5'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_addr = 8'h50;
    wait_done("busy1", lat);
    chk("busy1_latency", 32'(lat), 32'd25);
    chk("busy1_mem40", 32'(wr_log[8'h40]), 32'hC0);
    chk("busy1_mem50", 32'(wr_log[8'h50]), 32'h00);
    @(posedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done("busy2", lat);
    chk("busy2_latency", 32'(lat), 32'd25);
    chk("busy2_mem50", 32'(wr_log[8'h50]), 32'hC0);

    // Over-long burst is clamped to 16
    wr_base = 8'h00;
    issue(1'b1, 1'b0, 8'h00, 8'h80, 5'd20);
    wait_done("clamp", lat);
    chk("clamp_latency", 32'(lat), 32'd385);
    chk("clamp_mem8F", 32'(wr_log[8'h8F]), 32'h0F);
    chk("clamp_mem90", 32'(wr_log[8'h90]), 32'h00);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got running expected finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
